// File: rtl/paddle_ctl_mc.sv
// paddle_ctl_mc - multi-channel paddle controller for the A2601 core.
// Each channel picks a position source (analog paddle, analog stick or PS/2
// mouse), selects the stick/mouse axis, optionally inverts it, and drives an
// 8-bit paddle position plus a fire bit. The position can be slew-limited,
// stepping on ticks of an internal prescaler.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   inv         invert all position outputs
//   slew_en     enable slew limiting of a_out
//   mouse_ch    channel the mouse drives
//   stick_btn   per-channel stick-mode button (NCH)
//   paddle_btn  per-channel paddle-mode button (NCH)
//   joy_a       per channel {Y[15:8], X[7:0]}, signed (16*NCH)
//   paddle      per-channel paddle position, offset binary (8*NCH)
//   ps2_mouse   [24] strobe, [23:16] dy, [15:8] dx, [5] dy sign, [4] dx sign, [1:0] buttons
//   b_out       per-channel fire (NCH)
//   a_out       per-channel position (8*NCH)
//
// Per-channel source state:
//   state      | meaning
//   SRC_PADDLE | position from paddle input, fire from paddle_btn
//   SRC_STICK  | position from stick axis X/Y, fire from stick_btn
//   SRC_MOUSE  | position from mouse accumulator, fire from mouse buttons

module paddle_ctl_mc #(
   parameter int NCH          = 4,
   parameter int MOUSE_CLAMP  = 10,
   parameter int STICK_THRESH = 100,
   parameter int SLEW_STEP    = 4,
   parameter int SLEW_DIV     = 1024,
   localparam int MCW         = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int PW          = $clog2(SLEW_DIV)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              inv,
   input  logic              slew_en,
   input  logic [MCW-1:0]    mouse_ch,
   input  logic [NCH-1:0]    stick_btn,
   input  logic [NCH-1:0]    paddle_btn,
   input  logic [16*NCH-1:0] joy_a,
   input  logic [8*NCH-1:0]  paddle,
   input  logic [24:0]       ps2_mouse,
   output logic [NCH-1:0]    b_out,
   output logic [8*NCH-1:0]  a_out
);

   typedef enum logic [1:0] {
      SRC_PADDLE = 2'd0,
      SRC_STICK  = 2'd1,
      SRC_MOUSE  = 2'd2
   } src_t;

   localparam logic signed [9:0] CLAMP = 10'(MOUSE_CLAMP);
   localparam logic [7:0]        THR8  = 8'(STICK_THRESH);
   localparam logic [7:0]        STEP8 = 8'(SLEW_STEP);

   src_t              src   [NCH];
   logic [NCH-1:0]    xy;
   logic signed [7:0] mx    [NCH];
   logic signed [7:0] my    [NCH];
   logic [7:0]        tgt   [NCH];
   logic [7:0]        a_q   [NCH];
   logic [NCH-1:0]    b_q;
   logic [7:0]        tgt_d [NCH];
   logic [NCH-1:0]    fire_d;
   logic [PW-1:0]     presc;
   logic              strb_q;
   logic              strb_edge;
   logic              slew_tick;
   logic              unused_ps2;

   // dx[0], dy[0] and the unused flag bits of the mouse packet are ignored
   assign unused_ps2 = ^{ps2_mouse[16], ps2_mouse[8], ps2_mouse[7:6], ps2_mouse[3:2]};

   assign strb_edge = ps2_mouse[24] ^ strb_q;
   assign slew_tick = (presc == PW'(SLEW_DIV - 1));

   // Mouse delta is {sign,sign,mag[6:0]}; clamp it, add, saturate to 8-bit signed.
   function automatic logic signed [7:0] acc_sat(input logic signed [7:0] acc,
                                                 input logic sgn,
                                                 input logic [6:0] mag);
      logic signed [9:0] d;
      logic signed [9:0] s;
      d = {{3{sgn}}, mag};
      if (d > CLAMP)
         d = CLAMP;
      else if (d < -CLAMP)
         d = -CLAMP;
      s = {{2{acc[7]}}, acc} + d;
      if (s > 10'sd127)
         acc_sat = 8'sh7f;
      else if (s < -10'sd128)
         acc_sat = -8'sd128;
      else
         acc_sat = s[7:0];
   endfunction

   // Step toward the target by at most STEP8; never overshoots, so no wrap.
   function automatic logic [7:0] slew_to(input logic [7:0] cur, input logic [7:0] t);
      if (t > cur)
         slew_to = ((t - cur) <= STEP8) ? t : cur + STEP8;
      else if (cur > t)
         slew_to = ((cur - t) <= STEP8) ? t : cur - STEP8;
      else
         slew_to = cur;
   endfunction

   always_comb begin
      for (int ch = 0; ch < NCH; ch++) begin
         tgt_d[ch]  = {~paddle[8*ch+7], paddle[8*ch +: 7]};
         fire_d[ch] = paddle_btn[ch];
         case (src[ch])
            SRC_STICK: begin
               tgt_d[ch]  = xy[ch] ? joy_a[16*ch+8 +: 8] : joy_a[16*ch +: 8];
               fire_d[ch] = stick_btn[ch];
            end
            SRC_MOUSE: begin
               tgt_d[ch]  = xy[ch] ? my[ch] : mx[ch];
               fire_d[ch] = |ps2_mouse[1:0];
            end
            default: ;
         endcase
         tgt_d[ch] = tgt_d[ch] ^ {8{inv}};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         strb_q <= 1'b0;
         presc  <= '0;
         xy     <= '0;
         b_q    <= '0;
         for (int ch = 0; ch < NCH; ch++) begin
            src[ch] <= SRC_PADDLE;
            mx[ch]  <= '0;
            my[ch]  <= '0;
            tgt[ch] <= 8'h80;
            a_q[ch] <= 8'h80;
         end
      end else begin
         strb_q <= ps2_mouse[24];
         presc  <= slew_tick ? '0 : presc + 1'b1;
         b_q    <= fire_d;
         for (int ch = 0; ch < NCH; ch++) begin
            // later assignments take priority: paddle over stick over mouse
            if (strb_edge && (mouse_ch == MCW'(ch)))
               src[ch] <= SRC_MOUSE;
            if (stick_btn[ch])
               src[ch] <= SRC_STICK;
            if (paddle_btn[ch])
               src[ch] <= SRC_PADDLE;

            if (src[ch] == SRC_MOUSE) begin
               if (ps2_mouse[1])
                  xy[ch] <= 1'b1;
               if (ps2_mouse[0])
                  xy[ch] <= 1'b0;
            end else if (src[ch] == SRC_STICK) begin
               if (!joy_a[16*ch+15] && (joy_a[16*ch+8 +: 8] > THR8))
                  xy[ch] <= 1'b1;
               if (!joy_a[16*ch+7] && (joy_a[16*ch +: 8] > THR8))
                  xy[ch] <= 1'b0;
            end

            if (strb_edge && (mouse_ch == MCW'(ch))) begin
               mx[ch] <= acc_sat(mx[ch], ps2_mouse[4], ps2_mouse[15:9]);
               my[ch] <= acc_sat(my[ch], ps2_mouse[5], ps2_mouse[23:17]);
            end

            tgt[ch] <= tgt_d[ch];
            if (!slew_en)
               a_q[ch] <= tgt[ch];
            else if (slew_tick)
               a_q[ch] <= slew_to(a_q[ch], tgt[ch]);
         end
      end
   end

   always_comb begin
      b_out = b_q;
      a_out = '0;
      for (int ch = 0; ch < NCH; ch++)
         a_out[8*ch +: 8] = a_q[ch];
   end

endmodule

// File: tb/tb_paddle_ctl_mc.sv
module tb_paddle_ctl_mc;

   localparam int NCH = 4;
   localparam int CLAMP = 10;
   localparam int THRESH = 100;
   localparam int STEP = 4;
   localparam int DIV = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              inv = 1'b0;
   logic              slew_en = 1'b0;
   logic [1:0]        mouse_ch = '0;
   logic [NCH-1:0]    stick_btn = '0;
   logic [NCH-1:0]    paddle_btn = '0;
   logic [16*NCH-1:0] joy_a = '0;
   logic [8*NCH-1:0]  paddle = '0;
   logic [24:0]       ps2_mouse = '0;
   logic [NCH-1:0]    b_out;
   logic [8*NCH-1:0]  a_out;

   int n_assert = 0;
   int n_fail = 0;

   // reference model state (plain integers, mouse accumulators as signed ints)
   int m_src [NCH];   // 0 paddle, 1 stick, 2 mouse
   int m_xy  [NCH];
   int m_mx  [NCH];
   int m_my  [NCH];
   int m_tgt [NCH];
   int m_a   [NCH];
   int m_b   [NCH];
   int m_presc;
   int m_hist;

   paddle_ctl_mc #(
      .NCH(NCH), .MOUSE_CLAMP(CLAMP), .STICK_THRESH(THRESH),
      .SLEW_STEP(STEP), .SLEW_DIV(DIV)
   ) dut (
      .clk(clk), .reset_n(reset_n), .inv(inv), .slew_en(slew_en),
      .mouse_ch(mouse_ch), .stick_btn(stick_btn), .paddle_btn(paddle_btn),
      .joy_a(joy_a), .paddle(paddle), .ps2_mouse(ps2_mouse),
      .b_out(b_out), .a_out(a_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sgn8(input logic [7:0] v);
      return (v > 127) ? int'(v) - 256 : int'(v);
   endfunction

   function automatic int mouse_acc(input int acc, input logic s, input logic [6:0] mag);
      int d;
      d = int'(mag) - (s ? 128 : 0);
      if (d > CLAMP) d = CLAMP;
      if (d < -CLAMP) d = -CLAMP;
      acc = acc + d;
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      return acc;
   endfunction

   function automatic int step_to(input int cur, input int t);
      if (t > cur) return (t - cur <= STEP) ? t : cur + STEP;
      if (cur > t) return (cur - t <= STEP) ? t : cur - STEP;
      return cur;
   endfunction

   task automatic model_reset();
      for (int ch = 0; ch < NCH; ch++) begin
         m_src[ch] = 0; m_xy[ch] = 0; m_mx[ch] = 0; m_my[ch] = 0;
         m_tgt[ch] = 128; m_a[ch] = 128; m_b[ch] = 0;
      end
      m_presc = 0;
      m_hist = 0;
   endtask

   // one clock of behaviour, computed from the inputs present at the edge
   task automatic model_step();
      bit ev, tick;
      int t, y, x, nxy, ns;
      ev = (int'(ps2_mouse[24]) != m_hist);
      tick = (m_presc == DIV - 1);
      for (int ch = 0; ch < NCH; ch++) begin
         y = int'(joy_a[16*ch+8 +: 8]);
         x = int'(joy_a[16*ch +: 8]);
         if (m_src[ch] == 1) begin
            t = (m_xy[ch] != 0) ? y : x;
            m_b[ch] = int'(stick_btn[ch]);
         end else if (m_src[ch] == 2) begin
            t = ((m_xy[ch] != 0) ? m_my[ch] : m_mx[ch]) & 255;
            m_b[ch] = int'(|ps2_mouse[1:0]);
         end else begin
            t = int'(paddle[8*ch +: 8]) ^ 128;
            m_b[ch] = int'(paddle_btn[ch]);
         end
         if (inv) t = t ^ 255;
         if (!slew_en) m_a[ch] = m_tgt[ch];
         else if (tick) m_a[ch] = step_to(m_a[ch], m_tgt[ch]);
         m_tgt[ch] = t;
         nxy = m_xy[ch];
         if (m_src[ch] == 2) begin
            if (ps2_mouse[1]) nxy = 1;
            if (ps2_mouse[0]) nxy = 0;
         end else if (m_src[ch] == 1) begin
            if (sgn8(joy_a[16*ch+8 +: 8]) > THRESH) nxy = 1;
            if (sgn8(joy_a[16*ch +: 8]) > THRESH) nxy = 0;
         end
         m_xy[ch] = nxy;
         ns = m_src[ch];
         if (ev && ch == int'(mouse_ch)) begin
            ns = 2;
            m_mx[ch] = mouse_acc(m_mx[ch], ps2_mouse[4], ps2_mouse[15:9]);
            m_my[ch] = mouse_acc(m_my[ch], ps2_mouse[5], ps2_mouse[23:17]);
         end
         if (stick_btn[ch]) ns = 1;
         if (paddle_btn[ch]) ns = 0;
         m_src[ch] = ns;
      end
      m_hist = int'(ps2_mouse[24]);
      m_presc = (m_presc + 1) % DIV;
   endtask

   task automatic check_all();
      logic [NCH-1:0] eb;
      for (int ch = 0; ch < NCH; ch++) begin
         chk($sformatf("a_out%0d", ch), 32'(a_out[8*ch +: 8]), 32'(m_a[ch]));
         eb[ch] = m_b[ch][0];
      end
      chk("b_out", 32'(b_out), 32'(eb));
   endtask

   task automatic cyc();
      @(posedge clk);
      if (reset_n) model_step();
      #1;
      check_all();
   endtask

   task automatic set_joy(input int ch, input logic [7:0] y, input logic [7:0] x);
      joy_a[16*ch +: 16] = {y, x};
   endtask

   initial begin
      logic [7:0] seen [$];
      int at [$];
      logic [7:0] prev;
      bit found;

      model_reset();
      // reset with paddle 0 at 0x10
      paddle[7:0] = 8'h10;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_a0", 32'(a_out[7:0]), 32'h80);
      chk("rst_b", 32'(b_out), 32'h0);
      @(posedge clk); #1;
      check_all();
      @(posedge clk); #1;
      reset_n = 1'b1;
      cyc();
      cyc();
      chk("paddle0_after_release", 32'(a_out[7:0]), 32'h90);
      chk("b_after_release", 32'(b_out), 32'h0);

      // mouse on channel 1, dx=+50 repeated: clamps to +10/event, saturates at 127
      mouse_ch = 2'd1;
      ps2_mouse[15:8] = 8'd50;
      for (int i = 0; i < 15; i++) begin
         ps2_mouse[24] = ~ps2_mouse[24];
         cyc();
      end
      cyc();
      cyc();
      chk("mouse_sat_a1", 32'(a_out[15:8]), 32'h7f);
      chk("mouse_ch0_still_paddle", 32'(a_out[7:0]), 32'h90);

      // stick on channel 2: Y=110 deflects, X=20 does not
      set_joy(2, 8'd110, 8'd20);
      stick_btn[2] = 1'b1;
      cyc();
      stick_btn[2] = 1'b0;
      cyc(); cyc(); cyc();
      chk("stick_y_a2", 32'(a_out[23:16]), 32'd110);
      inv = 1'b1;
      cyc(); cyc();
      chk("stick_inv_a2", 32'(a_out[23:16]), 32'd145);
      chk("paddle_inv_a0", 32'(a_out[7:0]), 32'h6f);
      inv = 1'b0;

      // simultaneous buttons on channel 3: paddle wins
      paddle[31:24] = 8'h33;
      stick_btn[3] = 1'b1;
      paddle_btn[3] = 1'b1;
      cyc(); cyc();
      chk("both_btn_b3", 32'(b_out[3]), 32'h1);
      stick_btn[3] = 1'b0;
      paddle_btn[3] = 1'b0;
      cyc(); cyc();
      chk("both_btn_src_paddle_a3", 32'(a_out[31:24]), 32'hb3);

      // slew limiting: 0x80 -> 0x8A in steps of 4, one tick every DIV clocks
      paddle[7:0] = 8'h00;
      cyc(); cyc();
      chk("slew_start_a0", 32'(a_out[7:0]), 32'h80);
      slew_en = 1'b1;
      paddle[7:0] = 8'h0a;
      prev = a_out[7:0];
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (a_out[7:0] !== prev) begin
            seen.push_back(a_out[7:0]);
            at.push_back(i);
            prev = a_out[7:0];
         end
         if (a_out[7:0] === 8'h8a) break;
      end
      chk("slew_nsteps", 32'(seen.size()), 32'd3);
      if (seen.size() == 3) begin
         chk("slew_step1", 32'(seen[0]), 32'h84);
         chk("slew_step2", 32'(seen[1]), 32'h88);
         chk("slew_step3", 32'(seen[2]), 32'h8a);
         chk("slew_gap12", 32'(at[1] - at[0]), 32'(DIV));
         chk("slew_gap23", 32'(at[2] - at[1]), 32'(DIV));
      end

      // reset mid-slew at 0x88
      slew_en = 1'b0;
      paddle[7:0] = 8'h00;
      cyc(); cyc();
      slew_en = 1'b1;
      paddle[7:0] = 8'h0a;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cyc();
         if (a_out[7:0] === 8'h88) found = 1'b1;
      end
      chk("reach_88", 32'(found), 32'h1);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_a0", 32'(a_out[7:0]), 32'h80);
      chk("async_rst_b", 32'(b_out), 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 1; i <= DIV; i++) begin
         cyc();
         chk($sformatf("presc_restart_e%0d", i), 32'(a_out[7:0]),
             (i < DIV) ? 32'h80 : 32'h84);
      end

      // randomized phase against the model
      for (int i = 0; i < 600; i++) begin
         paddle = {$urandom, $urandom};
         joy_a = {$urandom, $urandom};
         if ($urandom_range(7) == 0) inv = ~inv;
         if ($urandom_range(31) == 0) slew_en = ~slew_en;
         if ($urandom_range(15) == 0) mouse_ch = 2'($urandom_range(3));
         for (int ch = 0; ch < NCH; ch++) begin
            stick_btn[ch] = ($urandom_range(7) == 0);
            paddle_btn[ch] = ($urandom_range(9) == 0);
         end
         ps2_mouse[23:0] = 24'($urandom);
         if ($urandom_range(2) == 0) ps2_mouse[24] = ~ps2_mouse[24];
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/paddle_ctl_mc.md
Name: paddle_ctl_mc

Overview:
- Multi-channel successor to the single-channel paddle controller. One instance serves all NCH ports of the console core.
- Per channel it selects the input source: analog paddle, analog stick or PS/2 mouse. It also picks the stick/mouse axis, optionally inverts, and drives an 8-bit paddle position plus a fire bit into the A2601 core.
- New behaviour over the single-channel version:
  - mouse routed to any one channel at run time;
  - optional slew-rate limiting of the position output, ticked by an internal prescaler.

Parameters:
- NCH, 4, number of paddle channels (1..8).
- MOUSE_CLAMP, 10, magnitude clamp applied to each mouse delta before accumulation.
- STICK_THRESH, 100, stick-axis deflection that selects that axis (compare is strictly greater than).
- SLEW_STEP, 4, maximum change of a_out per slew tick.
- SLEW_DIV, 1024, clk cycles per slew tick (>=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- inv  in  1  invert all position outputs.
- slew_en  in  1  enable slew limiting.
- mouse_ch  in  $clog2(NCH) (min 1)  channel the mouse drives.
- stick_btn  in  NCH  per-channel stick-mode button.
- paddle_btn  in  NCH  per-channel paddle-mode button.
- joy_a  in  16*NCH  per channel: {Y[15:8], X[7:0]}, signed.
- paddle  in  8*NCH  per-channel paddle position, offset binary.
- ps2_mouse  in  25  [24] toggle strobe, [23:16] dy, [15:8] dx, [5] dy sign, [4] dx sign, [1:0] buttons.
- b_out  out  NCH  per-channel fire.
- a_out  out  8*NCH  per-channel position.

Behaviour:
- Async reset (reset_n=0), all channels:
  - src=PADDLE, xy=0, mx=my=0;
  - a_out=8'h80 (centre), b_out=0;
  - slew prescaler=0, strobe history=0.
- Source state per channel (PADDLE=0, STICK=1, MOUSE=2). Evaluated each clk, last rule wins:
  - mouse strobe edge (ps2_mouse[24] != registered copy) and ch==mouse_ch -> MOUSE;
  - stick_btn[ch] -> STICK;
  - paddle_btn[ch] -> PADDLE.
- Mouse accumulation, only for channel mouse_ch, on the strobe edge:
  - dx is 9-bit signed {sign,sign,dx[7:1]}; dy likewise from [23:17].
  - Each delta is clamped to ±MOUSE_CLAMP.
  - nmx=mx+dx_c is saturated to [-128,127] and stored.
  - my is handled identically.
  - Other channels keep their accumulators.
  - Changing mouse_ch does not clear any accumulator.
- Axis select xy:
  - In MOUSE: button[1] -> xy=1; button[0] -> xy=0 (button[0] wins if both pressed).
  - In STICK: Y non-negative and >STICK_THRESH -> 1; X non-negative and >STICK_THRESH -> 0 (X wins).
  - In PADDLE: xy holds.
- Target, registered (stage 1):
  - PADDLE: {~paddle[7],paddle[6:0]};
  - STICK: xy?Y:X;
  - MOUSE: xy?my[7:0]:mx[7:0].
  - Then XOR with {8{inv}}.
- Output (stage 2), slew_en=0: a_out=target. Total latency from input change to a_out is 2 clk.
- Output (stage 2), slew_en=1: a_out updates only on a slew tick, i.e. one clk pulse when the prescaler wraps SLEW_DIV-1 -> 0.
  - |target-a_out| <= SLEW_STEP -> a_out=target.
  - Otherwise a_out moves SLEW_STEP toward target.
  - Compare is unsigned 8-bit; a_out never wraps past 0 or 255.
- Toggling slew_en 1->0 makes a_out jump to target on the next clk.
- Fire b_out (registered, 1 clk): PADDLE -> paddle_btn; STICK -> stick_btn; MOUSE -> |ps2_mouse[1:0].
- Simultaneous stick_btn and paddle_btn on one channel: PADDLE.
- Reset asserted mid-slew: a_out returns to 8'h80 immediately; the prescaler restarts.

Test Plan:
- Reset, paddle[0]=8'h10, inv=0, slew_en=0 -> a_out[0]=8'h80 during reset; 2 clk after release a_out[0]=8'h90, b_out=0.
- mouse_ch=1, strobe toggle with dx=+50 repeated 15 times -> ch1 src=MOUSE, mx clamps +10/event, saturates at 127, a_out[1]=8'h7F; ch0 remains PADDLE.
- ch2 stick_btn pulse, Y=8'd110, X=8'd20 -> xy=1, a_out[2]=8'd110; same with inv=1 -> 8'd145 (~110).
- slew_en=1, SLEW_DIV=4, SLEW_STEP=4, target jumps 8'h80->8'h8A -> a_out 84, 88, 8A on successive ticks, 4 clk apart.
- Same cycle stick_btn[3]=1 and paddle_btn[3]=1 -> src PADDLE, b_out[3]=1.
- Assert reset_n=0 mid-slew at a_out=8'h88 -> a_out=8'h80 asynchronously, prescaler=0.
